// File: rtl/adt7301_reader.sv
// adt7301_reader: round-robin SPI read master for the ADT7301 board thermometers.
module adt7301_reader #(
    parameter int N_SENS      = 3,
    parameter int SCLK_HALF   = 4,
    parameter int POLL_PERIOD = 40000000
) (
    input  logic                    dtc_clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    read_req,
    output logic [N_SENS-1:0]       adt_cs_b,
    output logic                    adt_sclk,
    output logic                    adt_din,
    input  logic                    adt_dout,
    output logic [N_SENS-1:0][13:0] temp,
    output logic [N_SENS-1:0]       temp_vld,
    output logic [N_SENS-1:0]       temp_err,
    output logic                    upd,
    output logic [1:0]              upd_idx,
    output logic                    busy
);
    localparam int CW = $clog2(2 * SCLK_HALF);
    localparam int TW = $clog2(POLL_PERIOD + 1);
    localparam logic [CW-1:0] HALF     = CW'(SCLK_HALF);
    localparam logic [CW-1:0] HALF_END = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] FULL_END = CW'(2 * SCLK_HALF - 1);
    localparam logic [TW-1:0] POLL_END = TW'(POLL_PERIOD - 1);
    localparam logic [1:0]    LAST     = 2'(N_SENS - 1);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic [1:0]      idx;
    logic [TW-1:0]   timer;
    logic            pend;
    logic [1:0]      sync;
    logic [15:0]     word;
    logic            half_end, full_end, cs_on;
    always_comb begin
        state_nx = state;
        half_end = cnt == HALF_END;
        full_end = cnt == FULL_END;
        case (state)
            IDLE:    state_nx = (pend || read_req || (enable && timer == POLL_END)) ? SETUP : IDLE;
            SETUP:   state_nx = half_end ? SHIFT : SETUP;
            SHIFT:   state_nx = (full_end && &bit_cnt) ? HOLD : SHIFT;
            HOLD:    state_nx = full_end ? GAP : HOLD;
            GAP:     state_nx = half_end ? (idx == LAST ? IDLE : SETUP) : GAP;
            default: state_nx = IDLE;
        endcase
        // HOLD is two half-periods: CS low for the first, released for the second
        cs_on    = state == SETUP || state == SHIFT || (state == HOLD && cnt < HALF);
        adt_cs_b = ~(N_SENS'(cs_on) << idx);
        adt_sclk = !(state == SHIFT && cnt < HALF);
    end
    assign adt_din = 1'b0;
    assign busy    = state != IDLE;
    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            timer    <= '0;
            pend     <= 1'b0;
            sync     <= '0;
            word     <= '0;
            temp     <= '0;
            temp_vld <= '0;
            temp_err <= '0;
            upd      <= 1'b0;
            upd_idx  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == IDLE || state_nx != state || (state == SHIFT && full_end)) ? '0 : cnt + CW'(1);
            sync  <= {sync[0], adt_dout};
            timer <= (state != IDLE || state_nx != IDLE) ? '0 : enable ? timer + TW'(1) : timer;
            pend  <= busy ? (pend || read_req) : 1'b0;
            upd   <= 1'b0;
            if (state == SHIFT && full_end) begin
                word    <= {word[14:0], sync[1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == GAP && half_end)
                idx <= idx == LAST ? '0 : idx + 2'd1;
            // results land together with upd on the first GAP cycle
            if (state == HOLD && full_end) begin
                upd     <= 1'b1;
                upd_idx <= idx;
                for (int s = 0; s < N_SENS; s++) begin
                    if (idx == 2'(s)) begin
                        temp_err[s] <= |word[15:14];
                        if (word[15:14] == 2'b00) begin
                            temp[s]     <= word[13:0];
                            temp_vld[s] <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adt7301_reader.sv
// tb_adt7301_reader: table vectors plus timing, reset and request-merging sequences.
module tb_adt7301_reader;
    localparam int N = 3;
    logic              dtc_clk = 1'b0, rst = 1'b1, enable = 1'b0, read_req = 1'b0, adt_dout = 1'b1;
    logic [N-1:0]      adt_cs_b;
    logic              adt_sclk, adt_din, upd, busy;
    logic [N-1:0][13:0] temp;
    logic [N-1:0]      temp_vld, temp_err;
    logic [1:0]        upd_idx;
    int tests = 0, fails = 0;
    always #5 dtc_clk = ~dtc_clk;
    adt7301_reader #(.N_SENS(N), .SCLK_HALF(4), .POLL_PERIOD(1000)) dut (
        .dtc_clk(dtc_clk), .rst(rst), .enable(enable), .read_req(read_req),
        .adt_cs_b(adt_cs_b), .adt_sclk(adt_sclk), .adt_din(adt_din), .adt_dout(adt_dout),
        .temp(temp), .temp_vld(temp_vld), .temp_err(temp_err),
        .upd(upd), .upd_idx(upd_idx), .busy(busy)
    );
    typedef struct { logic [1:0] idx; logic [13:0] t; logic v; logic e; } exp_t;
    // packed fields are ordered sensor 2, 1, 0
    typedef struct { logic [N-1:0][15:0] w; logic [N-1:0][13:0] t; logic [N-1:0] v; logic [N-1:0] e; } vec_t;
    exp_t        sb[$];
    exp_t        e;
    vec_t        vecs [4];
    logic [15:0] sens_word [N];
    logic [13:0] m_temp [N];
    logic        m_vld [N];
    logic        m_err [N];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic push_one(input int s);
        logic [15:0] w;
        w = sens_word[s];
        if (w[15:14] == 2'b00) begin
            m_temp[s] = w[13:0];
            m_vld[s]  = 1'b1;
            m_err[s]  = 1'b0;
        end else m_err[s] = 1'b1;
        sb.push_back('{2'(s), m_temp[s], m_vld[s], m_err[s]});
    endtask
    task automatic pulse_req();
        @(negedge dtc_clk) read_req = 1'b1;
        @(negedge dtc_clk) read_req = 1'b0;
    endtask
    task automatic wait_level(input string nm, input logic lvl, input int max);
        bit done = 1'b0;
        for (int i = 0; i < max && !done; i++) begin
            @(negedge dtc_clk);
            done = busy == lvl;
        end
        chk(nm, done, 1);
    endtask
    // sensor model: MSB presented on the first falling SCLK after CS drops
    int   bidx = 15;
    logic sclk_q = 1'b1;
    always @(adt_cs_b or adt_sclk) begin
        if (&adt_cs_b) bidx = 15;
        else if (sclk_q && !adt_sclk && bidx >= 0) begin
            for (int s = 0; s < N; s++)
                if (!adt_cs_b[s]) adt_dout = sens_word[s][bidx[3:0]];
            bidx--;
        end
        sclk_q = adt_sclk;
    end
    int cyc = 0, cs_len = 0, rises = 0, last_len = 0, last_rise = 0;
    int upd_total = 0, upd_cyc = 0, last_gap = 0, overlap = 0, sclk_bad = 0;
    logic [N-1:0] pcs = '1;
    logic         psclk = 1'b1;
    always @(negedge dtc_clk) begin
        cyc++;
        if (rst) begin
            cs_len = 0;
            rises  = 0;
        end else begin
            if ($countones(~adt_cs_b) > 1) overlap++;
            if (&adt_cs_b && !adt_sclk) sclk_bad++;
            if (!(&adt_cs_b)) cs_len++;
            if (adt_sclk && !psclk) rises++;
            if (&adt_cs_b && !(&pcs)) begin
                last_len  = cs_len;
                last_rise = rises;
                cs_len    = 0;
                rises     = 0;
            end
            if (upd) begin
                upd_total++;
                last_gap = cyc - upd_cyc;
                upd_cyc  = cyc;
                if (sb.size() == 0) chk("upd_unexpected", 32'(sb.size()), 1);
                else begin
                    e = sb.pop_front();
                    chk("upd_idx", upd_idx, e.idx);
                    chk("sb_temp", temp[e.idx], e.t);
                    chk("sb_vld", temp_vld[e.idx], e.v);
                    chk("sb_err", temp_err[e.idx], e.e);
                end
            end
        end
        pcs   = adt_cs_b;
        psclk = adt_sclk;
    end
    initial begin
        int   n, r, u0;
        logic ps;
        vecs[0] = '{w: {16'hFFFF, 16'h3CE0, 16'h0320}, t: {14'h0000, 14'h3CE0, 14'h0320}, v: 3'b011, e: 3'b100};
        vecs[1] = '{w: {16'h0001, 16'h2000, 16'h1FFF}, t: {14'h0001, 14'h2000, 14'h1FFF}, v: 3'b111, e: 3'b000};
        vecs[2] = '{w: {16'h0000, 16'h8320, 16'h4000}, t: {14'h0000, 14'h2000, 14'h1FFF}, v: 3'b111, e: 3'b011};
        vecs[3] = '{w: {16'hFFFF, 16'h3FFF, 16'hC000}, t: {14'h0000, 14'h3FFF, 14'h1FFF}, v: 3'b111, e: 3'b101};
        for (int s = 0; s < N; s++) begin
            m_temp[s] = '0;
            m_vld[s]  = 1'b0;
            m_err[s]  = 1'b0;
            sens_word[s] = '1;
        end
        repeat (3) @(posedge dtc_clk);
        #1;
        chk("rst_cs", adt_cs_b, 3'b111);
        chk("rst_sclk", adt_sclk, 1'b1);
        chk("rst_din", adt_din, 1'b0);
        chk("rst_temp", temp, 42'd0);
        chk("rst_vld", temp_vld, 3'b000);
        chk("rst_err", temp_err, 3'b000);
        chk("rst_upd", {upd, upd_idx}, 3'b000);
        chk("rst_busy", busy, 1'b0);
        @(negedge dtc_clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < N; s++) sens_word[s] = vecs[i].w[s];
            for (int s = 0; s < N; s++) push_one(s);
            pulse_req();
            wait_level("vec_idle_timeout", 1'b0, 1000);
            for (int s = 0; s < N; s++) begin
                chk($sformatf("vec%0d_temp%0d", i, s), temp[s], vecs[i].t[s]);
                chk($sformatf("vec%0d_vld%0d", i, s), temp_vld[s], vecs[i].v[s]);
                chk($sformatf("vec%0d_err%0d", i, s), temp_err[s], vecs[i].e[s]);
            end
            if (i == 0) chk("temp1_signed", 64'($signed(temp[1])), 64'(-800));
        end
        u0 = upd_total;
        for (int s = 0; s < N; s++) push_one(s);
        enable = 1'b1;
        wait_level("poll_start_timeout", 1'b1, 1200);
        wait_level("poll_idle_timeout", 1'b0, 1000);
        chk("cs_low_cycles", last_len, 136);
        chk("sclk_rises", last_rise, 16);
        chk("txn_period", last_gap, 144);
        for (int s = 0; s < N; s++) push_one(s);
        n = 0;
        while (!busy && n < 1200) begin
            n++;
            @(negedge dtc_clk);
        end
        chk("poll_idle_gap", n, 1000);
        repeat (200) @(negedge dtc_clk);
        enable = 1'b0;
        wait_level("disable_idle_timeout", 1'b0, 1000);
        chk("poll_upd_count", upd_total - u0, 6);
        n = 0;
        repeat (1500) begin
            @(negedge dtc_clk);
            if (busy) n++;
        end
        chk("no_poll_when_disabled", n, 0);
        chk("cs_overlap", overlap, 0);
        chk("sclk_idle_toggle", sclk_bad, 0);
        push_one(0);
        pulse_req();
        r  = 0;
        ps = 1'b1;
        for (int i = 0; i < 800 && r < 8; i++) begin
            @(negedge dtc_clk);
            if (adt_cs_b == 3'b101 && adt_sclk && !ps) r++;
            ps = adt_sclk;
        end
        chk("s1_8th_rise_seen", r, 8);
        rst = 1'b1;
        @(posedge dtc_clk);
        #1;
        chk("midrst_cs", adt_cs_b, 3'b111);
        chk("midrst_sclk", adt_sclk, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_upd", {upd, upd_idx}, 3'b000);
        chk("midrst_temp", temp, 42'd0);
        chk("midrst_flags", {temp_vld, temp_err}, 6'd0);
        @(negedge dtc_clk) rst = 1'b0;
        for (int s = 0; s < N; s++) begin
            m_temp[s] = '0;
            m_vld[s]  = 1'b0;
            m_err[s]  = 1'b0;
        end
        chk("midrst_sb_drained", 32'(sb.size()), 0);
        n = 0;
        repeat (600) begin
            @(negedge dtc_clk);
            if (busy) n++;
        end
        chk("midrst_stays_idle", n, 0);
        u0 = upd_total;
        for (int k = 0; k < 2; k++)
            for (int s = 0; s < N; s++) push_one(s);
        pulse_req();
        repeat (48) @(negedge dtc_clk);
        pulse_req();
        repeat (1500) @(negedge dtc_clk);
        chk("req_merge_upds", upd_total - u0, 6);
        chk("req_merge_busy", busy, 1'b0);
        chk("req_merge_sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
